// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus carry flop, LSB first.
// Result and carry-out are registered and flagged by a one-cycle done pulse.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] s_sr_q, s_sr_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic             s_bit;
   logic             c_nxt;
   logic [WIDTH-1:0] s_shift;

   // Single full-adder cell working on the current LSBs
   always_comb begin
      s_bit   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
      c_nxt   = (a_sr_q[0] & b_sr_q[0]) |
                (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
      s_shift = {s_bit, s_sr_q[WIDTH-1:1]};
   end

   // Next-state: load on accepted start, shift per bit, publish on last bit
   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      s_sr_d  = s_sr_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               a_sr_d  = a;
               b_sr_d  = b;
               s_sr_d  = '0;
               carry_d = cin;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            s_sr_d  = s_shift;
            carry_d = c_nxt;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
               sum_d   = s_shift;
               cout_d  = c_nxt;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State registers, cleared asynchronously so an abort drops everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q == S_RUN) || (state_q == S_DONE);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder (WIDTH=8)
// against an arithmetic reference {cout,sum} = a + b + cin.
module tb_serial_adder;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_sum  = '0;
   logic       exp_cout = 1'b0;

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model(input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc);
      logic [8:0] full;
      full = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
      exp_sum  = full[7:0];
      exp_cout = full[8];
   endtask

   // Wait for done, returning edges counted since the caller's last tick
   task automatic wait_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic do_op(input string tag, input logic [7:0] ta,
                        input logic [7:0] tb, input logic tc);
      int lat;
      start = 1'b1;
      a = ta;
      b = tb;
      cin = tc;
      tick();
      start = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
      check({tag, "_busy0"}, 32'(busy), 32'd1);
      check({tag, "_hold"}, 32'({cout, sum}), 32'({exp_cout, exp_sum}));
      wait_done(lat);
      model(ta, tb, tc);
      check({tag, "_lat"}, 32'(lat), 32'd8);
      check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
      check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
      tick();
      check({tag, "_pulse"}, 32'({busy, done}), 32'd0);
   endtask

   initial begin
      int lat;
      int ndone;
      logic [7:0] pa, pb;
      logic pc;

      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      #1;
      check("reset", 32'({busy, done, cout, sum}), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("idle", 32'({busy, done}), 32'd0);

      do_op("basic", 8'h3C, 8'h0A, 1'b0);
      do_op("ripple1", 8'hFF, 8'h01, 1'b0);
      do_op("ripple2", 8'hFF, 8'hFF, 1'b1);

      // lockout: a second start at E3 must be ignored
      start = 1'b1;
      a = 8'h01;
      b = 8'h01;
      cin = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1;
      a = 8'h80;
      b = 8'h80;
      tick();
      start = 1'b0;
      wait_done(lat);
      check("lock_lat", 32'(lat + 3), 32'd8);
      model(8'h01, 8'h01, 1'b0);
      check("lock_sum", 32'({cout, sum}), 32'({exp_cout, exp_sum}));
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) ndone++;
      end
      check("lock_single", 32'(ndone), 32'd0);

      // reset mid-operation
      start = 1'b1;
      a = 8'h55;
      b = 8'hAA;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("abort", 32'({busy, done, cout, sum}), 32'd0);
      exp_sum = '0;
      exp_cout = 1'b0;
      tick();
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) ndone++;
      end
      check("abort_nodone", 32'(ndone), 32'd0);
      do_op("post_rst", 8'h12, 8'h34, 1'b0);

      // back-to-back with start held high
      for (int k = 0; k < 4; k++) begin
         pa = 8'($urandom);
         pb = 8'($urandom);
         pc = 1'($urandom);
         start = 1'b1;
         a = pa;
         b = pb;
         cin = pc;
         tick();
         check("b2b_acc", 32'(busy), 32'd1);
         check("b2b_hold", 32'({cout, sum}), 32'({exp_cout, exp_sum}));
         lat = 0;
         while (done !== 1'b1 && lat < 20) begin
            a = 8'($urandom);
            b = 8'($urandom);
            cin = 1'($urandom);
            tick();
            lat++;
         end
         model(pa, pb, pc);
         check("b2b_lat", 32'(lat), 32'd8);
         check("b2b_res", 32'({cout, sum}), 32'({exp_cout, exp_sum}));
         a = 8'($urandom);
         b = 8'($urandom);
         tick();
         check("b2b_gap", 32'({busy, done}), 32'd0);
         check("b2b_keep", 32'({cout, sum}), 32'({exp_cout, exp_sum}));
      end
      start = 1'b0;
      tick();

      for (int i = 0; i < 200; i++) begin
         do_op("rand", 8'($urandom), 8'($urandom), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
